// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its pipeline registers.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } fetch_state_e;

  localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_0000;
  localparam int          PC_INC        = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: control from decode, the instruction-memory port and the IF/ID outputs.
interface fetch_stage_if #(
  parameter int ADDR_W = 8
);
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic [31:0]       if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic              if_id_valid;
  logic              halted;

  modport master (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid, halted
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid, halted
  );
endinterface

// File: rtl/if_id_reg.sv
// Pipeline register carrying an instruction word, its PC and a valid bit.
// Flush wins over capture; with neither asserted the contents hold.
module if_id_reg #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = fetch_pkg::DEF_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_capture,
  input  logic              i_flush,
  input  logic [31:0]       i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_valid
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_instr <= NOP_WORD;
      o_pc    <= '0;
      o_valid <= 1'b0;
    end else if (i_flush) begin
      o_instr <= NOP_WORD;
      o_valid <= 1'b0;
    end else if (i_capture) begin
      o_instr <= i_instr;
      o_pc    <= i_pc;
      o_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IDLE/RUN/HALT control and IF/ID capture.
import fetch_pkg::*;

module fetch_stage #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_WORD  = DEF_NOP_WORD,
  parameter logic [31:0]       HALT_WORD = DEF_HALT_WORD
) (
  input  logic             clk,
  input  logic             rst,
  fetch_stage_if.master    bus
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_halted;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_capture;
  logic              w_flush;
  logic              w_halt_hit;
  logic              w_unused_lsbs;

  // Redirect targets are forced word-aligned so the PC never leaves a 4-byte boundary.
  assign w_redirect_pc = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_unused_lsbs = ^bus.redirect_pc[1:0];

  assign bus.imem_addr = r_pc;
  assign bus.halted    = r_halted;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_capture  = 1'b0;
    w_flush    = 1'b0;
    w_halt_hit = 1'b0;
    if (r_state == ST_RUN) begin
      if (bus.redirect) begin
        w_flush = 1'b1;
      end else if (!bus.stall) begin
        // An X word fails this test and is therefore fetched as an ordinary instruction.
        if (bus.imem_instr == HALT_WORD) begin
          w_halt_hit = 1'b1;
          w_flush    = 1'b1;
        end else begin
          w_capture = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_RUN;
          if (bus.redirect) r_pc <= w_redirect_pc;
        end
        ST_RUN: begin
          if (bus.redirect) begin
            r_pc <= w_redirect_pc;
          end else if (w_halt_hit) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_capture) begin
            r_pc <= r_pc + PC_STEP;
          end
        end
        ST_HALT: begin
          if (bus.redirect) begin
            r_pc     <= w_redirect_pc;
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_flush   (w_flush),
    .i_instr   (bus.imem_instr),
    .i_pc      (r_pc),
    .o_instr   (bus.if_id_instr),
    .o_pc      (bus.if_id_pc),
    .o_valid   (bus.if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small table-driven instruction memory and per-scenario checks.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fetch_stage_if #(.ADDR_W(8)) bus ();

  fetch_stage #(
    .ADDR_W    (8),
    .RESET_PC  (8'h00),
    .NOP_WORD  (32'h0000_0013),
    .HALT_WORD (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h0000_7033;
      8'h04:   return 32'h0010_0093;
      8'h10:   return 32'h0040_8213;
      8'h48:   return 32'h02b0_2823;
      8'h4C:   return 32'h0300_2603;
      8'h50:   return 32'h0000_0000;
      8'hFC:   return 32'h00c0_0513;
      default: return 32'hA000_0000 | {24'h0, a};
    endcase
  endfunction

  assign bus.imem_instr = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 8'h00;
    #12;
    n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", bus.imem_addr); end
    n_checks++; if (bus.if_id_instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", bus.if_id_instr, NOP); end
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.if_id_valid); end
    n_checks++; if (bus.if_id_pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", bus.if_id_pc); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_run();
    step();
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", bus.if_id_valid); end
    n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL idle_addr: got %h want 00", bus.imem_addr); end
    step();
    n_checks++; if (bus.if_id_instr !== 32'h0000_7033) begin n_fail++; $display("FAIL first_instr: got %h want 00007033", bus.if_id_instr); end
    n_checks++; if (bus.if_id_pc !== 8'h00 || bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL first_pc: got pc %h valid %b want 00/1", bus.if_id_pc, bus.if_id_valid); end
    step();
    n_checks++; if (bus.if_id_instr !== 32'h0010_0093 || bus.if_id_pc !== 8'h04) begin n_fail++; $display("FAIL second_instr: got %h@%h want 00100093@04", bus.if_id_instr, bus.if_id_pc); end
    n_checks++; if (bus.imem_addr !== 8'h08) begin n_fail++; $display("FAIL second_addr: got %h want 08", bus.imem_addr); end
  endtask

  task automatic test_stall();
    step();
    step();
    n_checks++; if (bus.imem_addr !== 8'h10) begin n_fail++; $display("FAIL pre_stall_addr: got %h want 10", bus.imem_addr); end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.imem_addr !== 8'h10) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want 10", i, bus.imem_addr); end
      n_checks++; if (bus.if_id_instr !== 32'hA000_000C || bus.if_id_pc !== 8'h0C || bus.if_id_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_ifid[%0d]: got %h@%h v%b want a000000c@0c v1", i, bus.if_id_instr, bus.if_id_pc, bus.if_id_valid);
      end
    end
    bus.stall = 1'b0;
    step();
    n_checks++; if (bus.if_id_instr !== 32'h0040_8213 || bus.if_id_pc !== 8'h10) begin n_fail++; $display("FAIL resume_instr: got %h@%h want 00408213@10", bus.if_id_instr, bus.if_id_pc); end
    n_checks++; if (bus.imem_addr !== 8'h14) begin n_fail++; $display("FAIL resume_addr: got %h want 14", bus.imem_addr); end
  endtask

  task automatic test_redirect_over_stall();
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'h4B;
    step();
    n_checks++; if (bus.imem_addr !== 8'h48) begin n_fail++; $display("FAIL redir_addr: got %h want 48", bus.imem_addr); end
    n_checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP) begin n_fail++; $display("FAIL redir_flush: got %h v%b want 00000013 v0", bus.if_id_instr, bus.if_id_valid); end
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    step();
    n_checks++; if (bus.if_id_instr !== 32'h02b0_2823 || bus.if_id_pc !== 8'h48) begin n_fail++; $display("FAIL redir_fetch: got %h@%h want 02b02823@48", bus.if_id_instr, bus.if_id_pc); end
  endtask

  task automatic test_halt();
    step();
    n_checks++; if (bus.if_id_instr !== 32'h0300_2603 || bus.if_id_pc !== 8'h4C) begin n_fail++; $display("FAIL pre_halt: got %h@%h want 03002603@4c", bus.if_id_instr, bus.if_id_pc); end
    step();
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", bus.halted); end
    n_checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP) begin n_fail++; $display("FAIL halt_bubble: got %h v%b want 00000013 v0", bus.if_id_instr, bus.if_id_valid); end
    for (int i = 0; i < 4; i++) begin
      bus.stall = i[0];
      step();
      n_checks++; if (bus.imem_addr !== 8'h50 || bus.halted !== 1'b1 || bus.if_id_valid !== 1'b0) begin
        n_fail++; $display("FAIL halt_hold[%0d]: got addr %h h%b v%b want 50 h1 v0", i, bus.imem_addr, bus.halted, bus.if_id_valid);
      end
    end
    bus.stall = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'h00;
    step();
    bus.redirect = 1'b0;
    n_checks++; if (bus.halted !== 1'b0 || bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL unhalt: got h%b addr %h want h0 00", bus.halted, bus.imem_addr); end
    step();
    n_checks++; if (bus.if_id_instr !== 32'h0000_7033 || bus.if_id_pc !== 8'h00 || bus.if_id_valid !== 1'b1) begin
      n_fail++; $display("FAIL restart: got %h@%h v%b want 00007033@00 v1", bus.if_id_instr, bus.if_id_pc, bus.if_id_valid);
    end
  endtask

  task automatic test_wrap();
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'hFC;
    step();
    bus.redirect = 1'b0;
    n_checks++; if (bus.imem_addr !== 8'hFC) begin n_fail++; $display("FAIL wrap_target: got %h want fc", bus.imem_addr); end
    step();
    n_checks++; if (bus.if_id_instr !== 32'h00c0_0513 || bus.if_id_pc !== 8'hFC) begin n_fail++; $display("FAIL wrap_capture: got %h@%h want 00c00513@fc", bus.if_id_instr, bus.if_id_pc); end
    n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_pc: got %h want 00", bus.imem_addr); end
  endtask

  task automatic test_async_reset();
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'h1C;
    step();
    bus.redirect = 1'b0;
    step();
    n_checks++; if (bus.imem_addr !== 8'h20 || bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst: got addr %h v%b want 20 v1", bus.imem_addr, bus.if_id_valid); end
    #3 rst = 1'b1;
    #1;
    n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL async_addr: got %h want 00", bus.imem_addr); end
    n_checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP || bus.if_id_pc !== 8'h00) begin
      n_fail++; $display("FAIL async_ifid: got %h@%h v%b want 00000013@00 v0", bus.if_id_instr, bus.if_id_pc, bus.if_id_valid);
    end
    step();
    rst = 1'b0;
    step();
    n_checks++; if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL post_rst_idle: got v%b addr %h want v0 00", bus.if_id_valid, bus.imem_addr); end
    step();
    n_checks++; if (bus.if_id_instr !== 32'h0000_7033 || bus.if_id_pc !== 8'h00 || bus.if_id_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_fetch: got %h@%h v%b want 00007033@00 v1", bus.if_id_instr, bus.if_id_pc, bus.if_id_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_run();
    test_stall();
    test_redirect_over_stall();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
